spi_master_ctrl: RTL and testbench

- SPI master transfer controller (mode 0: CPOL=0, CPHA=0, MSB first) that sequences a TX FIFO and an RX FIFO.
- Pops one word from the TX FIFO, shifts it out on mosi while shifting miso in, then pushes the received word into the RX FIFO.
- Sits between the two FIFO instances and the SPI pins. It is the sole reader of the TX FIFO and the sole writer of the RX FIFO.

---
 rtl/spi_master_ctrl_if.sv | 29 ++
 rtl/spi_master_ctrl.sv | 117 +++++++++++
 tb/tb_spi_master_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Handshake bundle between spi_master_ctrl, its TX/RX FIFOs and the SPI pins.
// The controller connects through the master modport; FIFO and slave models use the slave modport.
interface spi_master_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] tx_data;
  logic             tx_empty;
  logic             tx_rd_en;
  logic [WIDTH-1:0] rx_data;
  logic             rx_full;
  logic             rx_wr_en;
  logic             done;
  logic             busy;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             cs_n;

  modport master (
    input  enable, tx_data, tx_empty, rx_full, miso,
    output tx_rd_en, rx_data, rx_wr_en, done, busy, sclk, mosi, cs_n
  );

  modport slave (
    output enable, tx_data, tx_empty, rx_full, miso,
    input  tx_rd_en, rx_data, rx_wr_en, done, busy, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: pops a TX FIFO word, shifts it out MSB first while shifting
// miso in, then pushes the received word into the RX FIFO.
module spi_master_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             sclk_q;
  logic             cs_n_q;
  logic             tx_rd_en_q;
  logic             rx_wr_en_q;
  logic             done_q;

  logic start;
  logic div_tc;

  assign start  = bus.enable && !bus.tx_empty && !bus.rx_full;
  assign div_tc = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  // NOTE: every register is updated with <= so all of them see the pre-edge
  // values of each other; a blocking assignment here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      tx_rd_en_q <= 1'b0;
      rx_wr_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_rd_en_q <= 1'b0;
      rx_wr_en_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            cs_n_q     <= 1'b0;
            tx_rd_en_q <= 1'b1;
          end
        end
        LOAD: begin
          tx_shift_q <= bus.tx_data;
          rx_shift_q <= '0;
          div_cnt_q  <= '0;
          bit_cnt_q  <= '0;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt_q <= '0;
            sclk_q    <= ~sclk_q;
            if (!sclk_q) begin
              rx_shift_q <= {rx_shift_q[WIDTH-2:0], bus.miso};
            end else begin
              bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
              // The last shift empties the register, so mosi idles low afterwards.
              tx_shift_q <= tx_shift_q << 1;
              if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                state_q    <= STORE;
                rx_data_q  <= rx_shift_q;
                rx_wr_en_q <= 1'b1;
                done_q     <= 1'b1;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        STORE: begin
          if (start) begin
            state_q    <= LOAD;
            tx_rd_en_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.tx_rd_en = tx_rd_en_q;
  assign bus.rx_wr_en = rx_wr_en_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = tx_shift_q[WIDTH-1];
  assign bus.cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: FIFO and SPI slave models plus a
// transfer-level timing model, directed scenarios and a randomized phase.
module tb_spi_master_ctrl;

  localparam int W        = 8;
  localparam int C        = 2;
  localparam int RX_DEPTH = 4;
  localparam int WORD_CYC = 2 * W * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.WIDTH(W)) bus ();
  spi_master_ctrl_if #(.WIDTH(W)) bus1 ();

  spi_master_ctrl #(.WIDTH(W), .CLK_DIV(C)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  spi_master_ctrl #(.WIDTH(W), .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  assign bus1.miso    = bus1.mosi;
  assign bus1.rx_full = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO contents, the words the model expects to be popped, and scripted slave replies.
  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];
  logic [W-1:0] exp_tx[$];
  logic [W-1:0] slave_q[$];

  int           cyc = 0;
  int           push_due, pop_cyc, rises;
  bit           in_flight, prev_avail, loopback, prev_sclk;
  bit           pend_pop, pend_push, saw_done;
  logic [W-1:0] cur_tx, cur_rx_exp, mosi_word, pend_data;
  int           done_cyc[$];

  task automatic drive_flags();
    bus.tx_empty = (tx_q.size() == 0);
    bus.tx_data  = (tx_q.size() == 0) ? '0 : tx_q[0];
    bus.rx_full  = (rx_q.size() >= RX_DEPTH);
  endtask

  task automatic push_tx(logic [W-1:0] w);
    tx_q.push_back(w);
    exp_tx.push_back(w);
    drive_flags();
  endtask

  task automatic drain_rx();
    rx_q.delete();
    drive_flags();
  endtask

  // Transfer-level model: a word starts the cycle after a start seen while idle or
  // storing, and its push lands 1 + 2*W*C cycles after the pop.
  task automatic sample(bit start_prev);
    bit exp_pop, exp_push, idle_now, rise;
    cyc++;
    exp_pop  = prev_avail && start_prev;
    exp_push = in_flight && (cyc == push_due);
    idle_now = !in_flight && !exp_pop;
    check("tx_rd_en", 32'(bus.tx_rd_en), 32'(exp_pop));
    check("rx_wr_en", 32'(bus.rx_wr_en), 32'(exp_push));
    check("done",     32'(bus.done),     32'(exp_push));
    check("cs_n",     32'(bus.cs_n),     32'(!(exp_pop || in_flight)));
    check("busy",     32'(bus.busy),     32'(exp_pop || in_flight));
    if (idle_now) begin
      check("idle_sclk", 32'(bus.sclk), 32'(0));
      check("idle_mosi", 32'(bus.mosi), 32'(0));
    end
    if (exp_pop) begin
      cur_tx = (exp_tx.size() > 0) ? exp_tx.pop_front() : '0;
      if (loopback)                cur_rx_exp = cur_tx;
      else if (slave_q.size() > 0) cur_rx_exp = slave_q.pop_front();
      else                         cur_rx_exp = W'($urandom);
      in_flight = 1'b1;
      pop_cyc   = cyc;
      push_due  = cyc + 1 + WORD_CYC;
      rises     = 0;
      mosi_word = '0;
      if (!loopback) bus.miso = cur_rx_exp[W-1];
    end
    rise = bus.sclk && !prev_sclk;
    if (rise && in_flight && !exp_pop) begin
      if (rises == 0) check("first_rise_cycle", 32'(cyc), 32'(pop_cyc + 1 + C));
      mosi_word = {mosi_word[W-2:0], bus.mosi};
      rises++;
      if (!loopback && rises < W) bus.miso = cur_rx_exp[W-1-rises];
    end
    if (loopback) bus.miso = bus.mosi;
    if (exp_push) begin
      check("rx_data",   32'(bus.rx_data), 32'(cur_rx_exp));
      check("mosi_word", 32'(mosi_word),   32'(cur_tx));
      check("sclk_rises", 32'(rises),      32'(W));
      in_flight = 1'b0;
    end
    prev_avail = exp_push || idle_now;
    prev_sclk  = bus.sclk;
    pend_pop   = bus.tx_rd_en;
    pend_push  = bus.rx_wr_en;
    pend_data  = bus.rx_data;
    saw_done   = bus.done;
    if (bus.done) done_cyc.push_back(cyc);
  endtask

  task automatic tick();
    bit st;
    st = bus.enable && (tx_q.size() != 0) && (rx_q.size() < RX_DEPTH);
    @(posedge clk);
    #1;
    if (pend_pop && tx_q.size() > 0) void'(tx_q.pop_front());
    if (pend_push) rx_q.push_back(pend_data);
    drive_flags();
    @(negedge clk);
    sample(st);
  endtask

  task automatic wait_done(int max_cyc, string tag);
    int n = 0;
    saw_done = 1'b0;
    do begin
      tick();
      n++;
    end while (!saw_done && n < max_cyc);
    check({tag, "_done_seen"}, 32'(saw_done), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int           t0;
    int           idx1, rises1, early_push;
    bit           pop1, prev_sclk1, saw1;
    logic [W-1:0] got1;
    logic [W-1:0] w1 [2] = '{8'h5A, 8'h96};

    bus.enable   = 1'b0;
    bus.miso     = 1'b0;
    bus1.enable  = 1'b0;
    bus1.tx_data = '0;
    bus1.tx_empty = 1'b1;
    prev_avail   = 1'b1;
    loopback     = 1'b1;
    drive_flags();

    repeat (2) @(negedge clk);
    check("rst_cs_n",     32'(bus.cs_n),     32'(1));
    check("rst_sclk",     32'(bus.sclk),     32'(0));
    check("rst_mosi",     32'(bus.mosi),     32'(0));
    check("rst_busy",     32'(bus.busy),     32'(0));
    check("rst_tx_rd_en", 32'(bus.tx_rd_en), 32'(0));
    check("rst_rx_wr_en", 32'(bus.rx_wr_en), 32'(0));
    check("rst_done",     32'(bus.done),     32'(0));
    check("rst_rx_data",  32'(bus.rx_data),  32'(0));
    rst  = 1'b0;
    rst1 = 1'b0;

    // Single word, miso looped back to mosi.
    push_tx(8'hA5);
    bus.enable = 1'b1;
    t0 = cyc;
    wait_done(60, "a5");
    check("a5_latency", 32'(cyc), 32'(t0 + 2 + WORD_CYC));
    tick();
    check("a5_tx_empty", 32'(tx_q.size()), 32'(0));
    check("a5_rx_count", 32'(rx_q.size()), 32'(1));
    check("a5_rx_word",  32'((rx_q.size() > 0) ? rx_q[0] : '1), 32'(8'hA5));
    drain_rx();

    // Slave answers 0x3C while the master sends 0xC3.
    loopback = 1'b0;
    slave_q.push_back(8'h3C);
    push_tx(8'hC3);
    wait_done(60, "c3");
    check("c3_rx",   32'(bus.rx_data), 32'(8'h3C));
    check("c3_mosi", 32'(mosi_word),   32'(8'hC3));
    tick();
    drain_rx();

    // Three-word burst: cs_n stays low and done pulses are one word apart.
    bus.enable = 1'b0;
    tick();
    loopback = 1'b1;
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    done_cyc.delete();
    bus.enable = 1'b1;
    for (int k = 0; k < 3; k++) wait_done(60, "burst");
    tick();
    check("burst_gap1", 32'(done_cyc.size() > 1 ? done_cyc[1] - done_cyc[0] : 0), 32'(2 + WORD_CYC));
    check("burst_gap2", 32'(done_cyc.size() > 2 ? done_cyc[2] - done_cyc[1] : 0), 32'(2 + WORD_CYC));
    check("burst_rx_count", 32'(rx_q.size()), 32'(3));
    for (int k = 0; k < 3 && k < rx_q.size(); k++)
      check("burst_rx_word", 32'(rx_q[k]), 32'(8'h11 * (k + 1)));
    drain_rx();

    // RX FIFO full blocks the start until one word is read out.
    bus.enable = 1'b0;
    tick();
    for (int k = 0; k < RX_DEPTH; k++) rx_q.push_back(W'(8'hF0 + k));
    push_tx(8'h5E);
    bus.enable = 1'b1;
    repeat (20) tick();
    check("full_hold_tx", 32'(tx_q.size()), 32'(1));
    void'(rx_q.pop_front());
    drive_flags();
    tick();
    check("full_restart", 32'(bus.tx_rd_en), 32'(1));
    wait_done(60, "full");
    tick();
    drain_rx();

    // enable dropped mid-word: that word finishes, the next one stays queued.
    bus.enable = 1'b0;
    tick();
    push_tx(8'hA1);
    push_tx(8'hB2);
    bus.enable = 1'b1;
    for (int n = 0; n < 60 && !(in_flight && rises >= 3); n++) tick();
    check("drop_reached_bit3", 32'(rises), 32'(3));
    bus.enable = 1'b0;
    wait_done(60, "drop");
    repeat (5) tick();
    check("drop_tx_left", 32'(tx_q.size()), 32'(1));
    check("drop_tx_head", 32'((tx_q.size() > 0) ? tx_q[0] : '0), 32'(8'hB2));
    check("drop_rx_word", 32'((rx_q.size() > 0) ? rx_q[0] : '0), 32'(8'hA1));
    drain_rx();

    // Randomized traffic with random slave replies, enable toggling and RX reads.
    loopback = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0 && tx_q.size() < 6) push_tx(W'($urandom));
      if ($urandom_range(0, 29) == 0) bus.enable = !bus.enable;
      if (rx_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        void'(rx_q.pop_front());
        drive_flags();
      end
      tick();
    end
    bus.enable = 1'b1;
    for (int n = 0; n < 4000 && !(tx_q.size() == 0 && !in_flight && !pend_pop); n++) begin
      if (rx_q.size() > 0) begin
        void'(rx_q.pop_front());
        drive_flags();
      end
      tick();
    end
    check("rand_tx_left",   32'(tx_q.size()), 32'(0));
    check("rand_in_flight", 32'(in_flight),   32'(0));
    bus.enable = 1'b0;

    // CLK_DIV=1 instance: reset in the middle of SHIFT drops the word in flight.
    idx1         = 0;
    rises1       = 0;
    early_push   = 0;
    pop1         = 1'b0;
    prev_sclk1   = 1'b0;
    bus1.tx_data  = w1[0];
    bus1.tx_empty = 1'b0;
    bus1.enable   = 1'b1;
    for (int n = 0; n < 60 && rises1 < 3; n++) begin
      @(posedge clk);
      #1;
      if (pop1 && idx1 < 2) begin
        idx1++;
        bus1.tx_empty = (idx1 >= 2);
        bus1.tx_data  = (idx1 >= 2) ? '0 : w1[idx1];
      end
      @(negedge clk);
      pop1 = bus1.tx_rd_en;
      if (bus1.rx_wr_en) early_push++;
      if (bus1.sclk && !prev_sclk1) rises1++;
      prev_sclk1 = bus1.sclk;
    end
    check("rst1_reached_shift", 32'(rises1), 32'(3));
    rst1 = 1'b1;
    #1;
    check("rst1_cs_n", 32'(bus1.cs_n), 32'(1));
    check("rst1_sclk", 32'(bus1.sclk), 32'(0));
    check("rst1_busy", 32'(bus1.busy), 32'(0));
    repeat (2) begin
      @(negedge clk);
      if (bus1.rx_wr_en) early_push++;
    end
    rst1 = 1'b0;
    pop1 = 1'b0;
    saw1 = 1'b0;
    got1 = '0;
    for (int n = 0; n < 80 && !saw1; n++) begin
      @(posedge clk);
      #1;
      if (pop1 && idx1 < 2) begin
        idx1++;
        bus1.tx_empty = (idx1 >= 2);
        bus1.tx_data  = (idx1 >= 2) ? '0 : w1[idx1];
      end
      @(negedge clk);
      pop1 = bus1.tx_rd_en;
      if (bus1.rx_wr_en) begin
        saw1 = 1'b1;
        got1 = bus1.rx_data;
      end
    end
    check("rst1_no_lost_push", 32'(early_push), 32'(0));
    check("rst1_push_seen",    32'(saw1),       32'(1));
    check("rst1_rx_word",      32'(got1),       32'(8'h96));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
